mult_div_control_unit: RTL
==========================

# mult_div_control_unit

Control unit for the multiply/divide datapath (`MultDivUnitDP`). It accepts one operation at a time through a start/done handshake and short-circuits three cases without iterating:
- repeated operands;
- division by zero;
- division overflow.

Otherwise it sequences the datapath enables through load, divisor alignment, complement, `parallelism` iterations and remainder correction. It sits between the core pipeline's execute stage and the datapath, and is the only driver of the datapath control inputs.

## Interface
Parameters:
- `parallelism`, 32: operand width; sets the iteration count.
- `opCode_width`, 3: opcode width; bit 2 = 1 selects division, 0 selects multiplication.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request; sampled only in IDLE.
- `opCode` in `opCode_width`: operation; latched when `start` is accepted.
- `flush` in 1: synchronous abort; wins over all other inputs.
- `res_ready` in 1: datapath says operands and op class equal the previous operation.
- `div_by_zero` in 1: datapath divisor-zero flag.
- `overflow_div` in 1: datapath division-overflow flag.
- `rem_neg` in 1: sign of the final partial remainder; sampled in CORR.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; result and flags valid.
- `err_div_zero` out 1: sticky until the next accepted start.
- `err_ovf` out 1: sticky until the next accepted start.
- `op_latched` out `opCode_width`: latched opcode, for result-half selection downstream.
- Datapath controls, all out:
  - `previousDataRegn_en` 1
  - `ad_en` 1
  - `divisor_lShift` 1
  - `notAd_en` 1
  - `sumH_sel` 2
  - `sumH_en` 1
  - `rev_en` 1

## Operation
- States: IDLE, LOAD, ALIGN, NEG, ITER, CORR, DONE.
- Datapath controls are Moore outputs decoded from the state. Every control is 0 in any state that does not list it below.
- **IDLE**
  - On `start`: latch `opCode` and clear both error flags.
  - Then branch, in priority order:
    1. Division and `div_by_zero`: set `err_div_zero`, go to DONE.
    2. Division and `overflow_div`: set `err_ovf`, go to DONE.
    3. `res_ready` and `prev_valid`: go to DONE (fast path).
    4. Otherwise: go to LOAD.
- **LOAD**
  - Asserts `ad_en`, `sumH_en`, `previousDataRegn_en`, with `sumH_sel`=00.
  - Next state: ALIGN for division, NEG for multiplication.
- **ALIGN** (division only)
  - Asserts `divisor_lShift` and `ad_en`.
  - Next state: NEG.
- **NEG**
  - Asserts `notAd_en`.
  - Loads the iteration counter with `parallelism`-1.
  - Next state: ITER.
- **ITER**
  - Asserts `sumH_en` with `sumH_sel`=01.
  - Decrements the counter each cycle.
  - When the counter reaches 0, go to CORR for division or DONE for multiplication.
- **CORR** (division only)
  - Asserts `sumH_en`, with `sumH_sel`=10 and `rev_en`=`rem_neg`.
  - Next state: DONE.
- **DONE**
  - `done`=1 for one cycle; no datapath enables.
  - Sets `prev_valid` when the operation completed with no error flag set.
  - Next state: IDLE.
- **prev_valid** (internal)
  - Cleared by reset and by `flush`.
  - Unaffected by error completions: they write no datapath register, so the previous result stays intact.
- **start while busy**: ignored, with no queuing.
- **flush**
  - From any state, go to IDLE on the next edge.
  - Clear `prev_valid`.
  - Outputs drop to IDLE values with no `done` pulse.
  - Error flags are left unchanged.
- **Counter**: `$clog2(parallelism)` bits; it never wraps because the state leaves ITER at 0.
- **Reset**
  - State IDLE, counter 0, `prev_valid`=0, `op_latched`=0.
  - `busy`, `done`, both error flags and all controls are 0.
  - Reset mid-operation abandons the operation immediately.

## Timing
- Accept edge = the edge where `start` is sampled in IDLE; cycle *n* = *n* cycles after it.
- Multiplication:
  - LOAD in cycle 1, NEG in cycle 2.
  - ITER in cycles 3 to `parallelism`+2.
  - `done` in cycle `parallelism`+3 (35 at default).
- Division:
  - LOAD in 1, ALIGN in 2, NEG in 3.
  - ITER in 4 to `parallelism`+3.
  - CORR in `parallelism`+4.
  - `done` in `parallelism`+5 (37 at default).
- Fast path and error paths: `done` in cycle 1.
- Back-to-back: the next `start` is accepted in the IDLE cycle after DONE. Minimum issue interval is 2 cycles (fast path), i.e. `start` can be accepted no earlier than the cycle after the `done` pulse.
- `busy` rises in the cycle after the accept edge and falls in the cycle after DONE.
- `op_latched` and the error flags are valid from cycle 1 and are stable through `done`.

## Test plan
- Multiply, `parallelism`=32, 7×6, `start` pulsed once:
  - exactly 32 ITER cycles;
  - `done` at cycle 35;
  - `previousDataRegn_en` high only in cycle 1.
- Divide 100/7:
  - `divisor_lShift` high only in cycle 2;
  - CORR in cycle 36 with `rev_en` equal to the driven `rem_neg` (drive both 0 and 1);
  - `done` at cycle 37.
- Divide with `div_by_zero`=1 and `overflow_div`=1 together:
  - `done` at cycle 1;
  - `err_div_zero`=1, `err_ovf`=0;
  - no datapath enable pulses;
  - flags cleared by the next accepted start.
- Repeat the same multiply with `res_ready`=1:
  - `done` at cycle 1, no enables.
  - Then `flush`, then repeat again: full 35-cycle run, because `prev_valid` was cleared.
- `flush` in ITER cycle 10:
  - IDLE next cycle, `busy`=0, no `done`.
  - A `start` during the run is ignored and does not accept.
- `rst_n` asserted low mid-CORR:
  - all outputs 0 immediately (asynchronous);
  - after release, a new multiply completes in 35 cycles.

Source files
------------

// File: rtl/mult_div_control_unit_if.sv
// Handshake and datapath-control bundle between the execute stage, the
// multiply/divide control unit and the MultDivUnitDP datapath.
interface mult_div_control_unit_if #(
  parameter int opCode_width = 3
);
  // Request side (execute stage / datapath status flags)
  logic                    start;
  logic [opCode_width-1:0] opCode;
  logic                    flush;
  logic                    res_ready;
  logic                    div_by_zero;
  logic                    overflow_div;
  logic                    rem_neg;

  // Status back to the pipeline
  logic                    busy;
  logic                    done;
  logic                    err_div_zero;
  logic                    err_ovf;
  logic [opCode_width-1:0] op_latched;

  // Datapath controls
  logic                    previousDataRegn_en;
  logic                    ad_en;
  logic                    divisor_lShift;
  logic                    notAd_en;
  logic [1:0]              sumH_sel;
  logic                    sumH_en;
  logic                    rev_en;

  // Issuer view: drives request and flags, observes status and controls
  modport master (
    output start, opCode, flush, res_ready, div_by_zero, overflow_div, rem_neg,
    input  busy, done, err_div_zero, err_ovf, op_latched,
    input  previousDataRegn_en, ad_en, divisor_lShift, notAd_en,
    input  sumH_sel, sumH_en, rev_en
  );

  // Control unit view
  modport slave (
    input  start, opCode, flush, res_ready, div_by_zero, overflow_div, rem_neg,
    output busy, done, err_div_zero, err_ovf, op_latched,
    output previousDataRegn_en, ad_en, divisor_lShift, notAd_en,
    output sumH_sel, sumH_en, rev_en
  );
endinterface

// File: rtl/mult_div_control_unit.sv
// Sequencer for the iterative multiply/divide datapath. Accepts one operation
// per start/done handshake, short-circuits divide-by-zero, divide overflow and
// repeated operands, and otherwise walks LOAD/ALIGN/NEG/ITER/CORR/DONE.
// opCode bit 2 selects division; op widths below 3 bits are not supported.
module mult_div_control_unit #(
  parameter int parallelism  = 32,
  parameter int opCode_width = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mult_div_control_unit_if.slave  bus
);

  localparam int               CNT_W    = (parallelism > 1) ? $clog2(parallelism) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(parallelism - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ALIGN = 3'd2,
    S_NEG   = 3'd3,
    S_ITER  = 3'd4,
    S_CORR  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    prev_valid_q, prev_valid_d;
  logic [opCode_width-1:0] op_q, op_d;
  logic                    err_div_zero_q, err_div_zero_d;
  logic                    err_ovf_q, err_ovf_d;

  logic start_is_div;
  logic op_is_div;

  // Moore output decode, gathered locally before driving the interface
  logic       busy_c;
  logic       done_c;
  logic       prev_en_c;
  logic       ad_en_c;
  logic       lshift_c;
  logic       not_ad_en_c;
  logic [1:0] sum_h_sel_c;
  logic       sum_h_en_c;
  logic       rev_en_c;

  // The incoming opcode decides the early-exit checks; the latched one steers the sequence
  assign start_is_div = bus.opCode[2];
  assign op_is_div    = op_q[2];

  // State and bookkeeping registers; reset abandons any operation at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      prev_valid_q   <= 1'b0;
      op_q           <= '0;
      err_div_zero_q <= 1'b0;
      err_ovf_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      prev_valid_q   <= prev_valid_d;
      op_q           <= op_d;
      err_div_zero_q <= err_div_zero_d;
      err_ovf_q      <= err_ovf_d;
    end
  end

  // Next-state logic; flush overrides everything but leaves error flags alone
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    prev_valid_d   = prev_valid_q;
    op_d           = op_q;
    err_div_zero_d = err_div_zero_q;
    err_ovf_d      = err_ovf_q;

    if (bus.flush) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      prev_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_d           = bus.opCode;
            err_div_zero_d = 1'b0;
            err_ovf_d      = 1'b0;
            if (start_is_div && bus.div_by_zero) begin
              err_div_zero_d = 1'b1;
              state_d        = S_DONE;
            end else if (start_is_div && bus.overflow_div) begin
              err_ovf_d = 1'b1;
              state_d   = S_DONE;
            end else if (bus.res_ready && prev_valid_q) begin
              // Datapath already holds this exact result
              state_d = S_DONE;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          state_d = op_is_div ? S_ALIGN : S_NEG;
        end
        S_ALIGN: begin
          state_d = S_NEG;
        end
        S_NEG: begin
          cnt_d   = CNT_LOAD;
          state_d = S_ITER;
        end
        S_ITER: begin
          // Leaving at zero means the counter never wraps
          if (cnt_q == '0) begin
            state_d = op_is_div ? S_CORR : S_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_CORR: begin
          state_d = S_DONE;
        end
        S_DONE: begin
          // Error completions touch no datapath register, so the old result survives
          if (!err_div_zero_q && !err_ovf_q) begin
            prev_valid_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Datapath controls and status decoded purely from the current state
  always_comb begin
    busy_c      = (state_q != S_IDLE);
    done_c      = 1'b0;
    prev_en_c   = 1'b0;
    ad_en_c     = 1'b0;
    lshift_c    = 1'b0;
    not_ad_en_c = 1'b0;
    sum_h_sel_c = 2'b00;
    sum_h_en_c  = 1'b0;
    rev_en_c    = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        ad_en_c     = 1'b1;
        sum_h_en_c  = 1'b1;
        prev_en_c   = 1'b1;
        sum_h_sel_c = 2'b00;
      end
      S_ALIGN: begin
        lshift_c = 1'b1;
        ad_en_c  = 1'b1;
      end
      S_NEG: begin
        not_ad_en_c = 1'b1;
      end
      S_ITER: begin
        sum_h_en_c  = 1'b1;
        sum_h_sel_c = 2'b01;
      end
      S_CORR: begin
        sum_h_en_c  = 1'b1;
        sum_h_sel_c = 2'b10;
        rev_en_c    = bus.rem_neg;
      end
      S_DONE: begin
        done_c = 1'b1;
      end
      default: begin
        done_c = 1'b0;
      end
    endcase
  end

  assign bus.busy                = busy_c;
  assign bus.done                = done_c;
  assign bus.err_div_zero        = err_div_zero_q;
  assign bus.err_ovf             = err_ovf_q;
  assign bus.op_latched          = op_q;
  assign bus.previousDataRegn_en = prev_en_c;
  assign bus.ad_en               = ad_en_c;
  assign bus.divisor_lShift      = lshift_c;
  assign bus.notAd_en            = not_ad_en_c;
  assign bus.sumH_sel            = sum_h_sel_c;
  assign bus.sumH_en             = sum_h_en_c;
  assign bus.rev_en              = rev_en_c;

endmodule
